// File: rtl/dram_request_arbiter.sv
// Shares the SDRAM controller command port between VGA (port 0), instruction fetch (port 1) and
// data (port 2), and schedules auto-refresh. Optional feature macro: DRAM_ARB_STARVATION_GUARD_EN.
module dram_request_arbiter #(
   parameter int ADDR_W         = 26,
   parameter int DATA_W         = 16,
   parameter int BURST_LEN      = 8,
   parameter int REFRESH_PERIOD = 700
) (
   input  logic                  main_clk,
   input  logic                  rst_n,
   input  logic [2:0]            req_valid,
   input  logic [2:0]            req_write,
   input  logic [3*ADDR_W-1:0]   req_addr,
   input  logic [3*DATA_W-1:0]   req_wdata,
   output logic [2:0]            req_ack,
   output logic [2:0]            wdata_pop,
   output logic [2:0]            rsp_valid,
   output logic [DATA_W-1:0]     rsp_data,
   output logic                  rsp_last,
   output logic                  ctl_cmd_valid,
   input  logic                  ctl_cmd_ready,
   output logic                  ctl_cmd_refresh,
   output logic                  ctl_cmd_write,
   output logic [ADDR_W-1:0]     ctl_cmd_addr,
   output logic [DATA_W-1:0]     ctl_wdata,
   input  logic                  ctl_wdata_pop,
   input  logic [DATA_W-1:0]     ctl_rdata,
   input  logic                  ctl_rdata_valid,
   input  logic                  ctl_done,
   output logic                  refresh_overrun,
   output logic                  protocol_err
);

   localparam int REF_W  = $clog2(REFRESH_PERIOD + 1);
   localparam int BEAT_W = $clog2(BURST_LEN) + 1;
   localparam logic [REF_W-1:0]  REF_RELOAD = REF_W'(REFRESH_PERIOD - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
   localparam logic [BEAT_W-1:0] BEAT_SAT   = BEAT_W'(BURST_LEN);
   localparam logic [BEAT_W:0]   BEATS_FULL = (BEAT_W + 1)'(BURST_LEN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_REFRESH,
      ST_REFRESH_WAIT,
      ST_XFER
   } state_t;

   state_t              state;
   logic [1:0]          gnt;
   logic                rr_ptr;          // 0: port 1 preferred, 1: port 2 preferred
   logic [REF_W-1:0]    ref_cnt;
   logic                refresh_pending;
   logic                refresh_tick;
   logic                refresh_clear;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [BEAT_W:0]     beat_total;
   logic                xfer;
   logic                beat;
   logic                stray_beat;
   logic                arb_hit;
   logic [1:0]          arb_port;
   logic [1:0]          starved;         // [0]: port 1, [1]: port 2

   assign xfer          = (state == ST_XFER);
   assign beat          = xfer && (ctl_rdata_valid || ctl_wdata_pop);
   assign stray_beat    = !xfer && (ctl_rdata_valid || ctl_wdata_pop);
   assign beat_total    = {1'b0, beat_cnt} + (BEAT_W + 1)'(beat);
   assign refresh_tick  = (ref_cnt == '0);
   assign refresh_clear = (state == ST_REFRESH) && ctl_cmd_ready;

`ifdef DRAM_ARB_STARVATION_GUARD_EN
   logic [5:0] wait_cnt [2];

   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt[0] <= '0;
         wait_cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (req_ack[i+1])
               wait_cnt[i] <= '0;
            else if (req_valid[i+1] && wait_cnt[i] != 6'd63)
               wait_cnt[i] <= wait_cnt[i] + 6'd1;
         end
      end
   end

   // A saturated counter only counts while the port is still asking.
   assign starved[0] = req_valid[1] && (wait_cnt[0] == 6'd63);
   assign starved[1] = req_valid[2] && (wait_cnt[1] == 6'd63);
`else
   assign starved = 2'b00;
`endif

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      arb_hit  = 1'b1;
      arb_port = 2'd0;
      if (starved[0])
         arb_port = 2'd1;
      else if (starved[1])
         arb_port = 2'd2;
      else if (req_valid[0])
         arb_port = 2'd0;
      else if (req_valid[1] && (!rr_ptr || !req_valid[2]))
         arb_port = 2'd1;
      else if (req_valid[2])
         arb_port = 2'd2;
      else
         arb_hit = 1'b0;
   end

   // Handshake and data-path strobes follow the controller in the same cycle.
   always_comb begin
      req_ack   = '0;
      wdata_pop = '0;
      rsp_valid = '0;
      if (state == ST_ISSUE && ctl_cmd_ready)
         req_ack[gnt] = 1'b1;
      if (xfer && ctl_wdata_pop)
         wdata_pop[gnt] = 1'b1;
      if (xfer && ctl_rdata_valid)
         rsp_valid[gnt] = 1'b1;
   end

   assign rsp_data  = (xfer && ctl_rdata_valid) ? ctl_rdata : '0;
   assign rsp_last  = beat && (beat_cnt == BEAT_LAST);
   assign ctl_wdata = (xfer && ctl_cmd_write) ? req_wdata[gnt*DATA_W +: DATA_W] : '0;

   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_cnt         <= REF_RELOAD;
         refresh_pending <= 1'b0;
         refresh_overrun <= 1'b0;
      end else begin
         if (refresh_tick) begin
            ref_cnt         <= REF_RELOAD;
            refresh_pending <= 1'b1;
            if (refresh_pending && !refresh_clear)
               refresh_overrun <= 1'b1;
         end else begin
            ref_cnt <= ref_cnt - 1'b1;
            if (refresh_clear)
               refresh_pending <= 1'b0;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         gnt             <= 2'd0;
         rr_ptr          <= 1'b0;
         ctl_cmd_valid   <= 1'b0;
         ctl_cmd_refresh <= 1'b0;
         ctl_cmd_write   <= 1'b0;
         ctl_cmd_addr    <= '0;
         beat_cnt        <= '0;
         protocol_err    <= 1'b0;
      end else begin
         if (stray_beat)
            protocol_err <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (refresh_pending) begin
                  state           <= ST_REFRESH;
                  ctl_cmd_valid   <= 1'b1;
                  ctl_cmd_refresh <= 1'b1;
                  ctl_cmd_write   <= 1'b0;
                  ctl_cmd_addr    <= '0;
               end else if (arb_hit) begin
                  state           <= ST_ISSUE;
                  gnt             <= arb_port;
                  ctl_cmd_valid   <= 1'b1;
                  ctl_cmd_refresh <= 1'b0;
                  ctl_cmd_write   <= req_write[arb_port];
                  ctl_cmd_addr    <= req_addr[arb_port*ADDR_W +: ADDR_W];
                  if (arb_port != 2'd0)
                     rr_ptr <= (arb_port == 2'd1);
               end
            end

            ST_ISSUE: begin
               // The latched command completes even if the requester withdraws early.
               if (!req_valid[gnt])
                  protocol_err <= 1'b1;
               if (ctl_cmd_ready) begin
                  state         <= ST_XFER;
                  ctl_cmd_valid <= 1'b0;
                  beat_cnt      <= '0;
               end
            end

            ST_REFRESH: begin
               if (ctl_cmd_ready) begin
                  state           <= ST_REFRESH_WAIT;
                  ctl_cmd_valid   <= 1'b0;
                  ctl_cmd_refresh <= 1'b0;
               end
            end

            ST_REFRESH_WAIT: begin
               if (ctl_done)
                  state <= ST_IDLE;
            end

            ST_XFER: begin
               if (beat && beat_cnt <= BEAT_SAT)
                  beat_cnt <= beat_cnt + 1'b1;
               if (ctl_done) begin
                  state <= ST_IDLE;
                  if (beat_total != BEATS_FULL)
                     protocol_err <= 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_request_arbiter.sv
// Directed bench for dram_request_arbiter: arbitration vector table plus hand-written burst,
// refresh, protocol-error and mid-burst reset sequences.
module tb_dram_request_arbiter;

   localparam int ADDR_W = 26;
   localparam int DATA_W = 16;
   localparam int BL     = 8;
   localparam logic [ADDR_W-1:0] A0 = 26'h0000100;
   localparam logic [ADDR_W-1:0] A1 = 26'h0001230;
   localparam logic [ADDR_W-1:0] A2 = 26'h0002000;

   logic                main_clk = 1'b0;
   logic                rst_n    = 1'b0;
   logic [2:0]          req_valid;
   logic [2:0]          req_write;
   logic [3*ADDR_W-1:0] req_addr;
   logic [3*DATA_W-1:0] req_wdata;
   logic                ctl_cmd_ready;
   logic                ctl_wdata_pop;
   logic [DATA_W-1:0]   ctl_rdata;
   logic                ctl_rdata_valid;
   logic                ctl_done;

   logic [2:0]          req_ack, wdata_pop, rsp_valid;
   logic [DATA_W-1:0]   rsp_data, ctl_wdata;
   logic                rsp_last, ctl_cmd_valid, ctl_cmd_refresh, ctl_cmd_write;
   logic [ADDR_W-1:0]   ctl_cmd_addr;
   logic                refresh_overrun, protocol_err;

   logic [2:0]          r_req_ack, r_wdata_pop, r_rsp_valid;
   logic [DATA_W-1:0]   r_rsp_data, r_wdata;
   logic                r_rsp_last, r_cmd_valid, r_cmd_refresh, r_cmd_write;
   logic [ADDR_W-1:0]   r_cmd_addr;
   logic                r_overrun, r_protocol_err;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int ack_cyc = 0;

   typedef struct {
      logic [2:0] valid;
      logic       exp_cmd;
      int         exp_port;
   } arb_vec_t;

   arb_vec_t vecs [8];

   dram_request_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .REFRESH_PERIOD(700)) dut (
      .main_clk(main_clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ack(req_ack), .wdata_pop(wdata_pop), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd_ready(ctl_cmd_ready),
      .ctl_cmd_refresh(ctl_cmd_refresh), .ctl_cmd_write(ctl_cmd_write), .ctl_cmd_addr(ctl_cmd_addr),
      .ctl_wdata(ctl_wdata), .ctl_wdata_pop(ctl_wdata_pop), .ctl_rdata(ctl_rdata),
      .ctl_rdata_valid(ctl_rdata_valid), .ctl_done(ctl_done),
      .refresh_overrun(refresh_overrun), .protocol_err(protocol_err)
   );

   dram_request_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .REFRESH_PERIOD(20)) dut_r (
      .main_clk(main_clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ack(r_req_ack), .wdata_pop(r_wdata_pop), .rsp_valid(r_rsp_valid), .rsp_data(r_rsp_data),
      .rsp_last(r_rsp_last), .ctl_cmd_valid(r_cmd_valid), .ctl_cmd_ready(ctl_cmd_ready),
      .ctl_cmd_refresh(r_cmd_refresh), .ctl_cmd_write(r_cmd_write), .ctl_cmd_addr(r_cmd_addr),
      .ctl_wdata(r_wdata), .ctl_wdata_pop(ctl_wdata_pop), .ctl_rdata(ctl_rdata),
      .ctl_rdata_valid(ctl_rdata_valid), .ctl_done(ctl_done),
      .refresh_overrun(r_overrun), .protocol_err(r_protocol_err)
   );

   always #5 main_clk = ~main_clk;
   always @(posedge main_clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge main_clk);
      #1;
   endtask

   function automatic logic [ADDR_W-1:0] port_addr(input int p);
      case (p)
         0:       return A0;
         1:       return A1;
         default: return A2;
      endcase
   endfunction

   task automatic do_reset();
      rst_n           = 1'b0;
      req_valid       = '0;
      ctl_cmd_ready   = 1'b0;
      ctl_wdata_pop   = 1'b0;
      ctl_rdata_valid = 1'b0;
      ctl_rdata       = '0;
      ctl_done        = 1'b0;
      repeat (2) @(posedge main_clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Acts as the SDRAM controller for one command: accept, BL beats, done.
   task automatic serve(output int port);
      int n;
      port = -1;
      n    = 0;
      while (!ctl_cmd_valid && n < 30) begin
         tick();
         n++;
      end
      if (!ctl_cmd_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL serve_timeout: ctl_cmd_valid=0, expected 1 within 30 cycles");
         return;
      end
      ctl_cmd_ready = 1'b1;
      #1;
      for (int p = 0; p < 3; p++)
         if (req_ack[p]) port = p;
      ack_cyc = cyc;
      tick();
      ctl_cmd_ready = 1'b0;
      for (int i = 0; i < BL; i++) begin
         if (ctl_cmd_write)
            ctl_wdata_pop = 1'b1;
         else begin
            ctl_rdata_valid = 1'b1;
            ctl_rdata       = DATA_W'(i);
         end
         tick();
      end
      ctl_wdata_pop   = 1'b0;
      ctl_rdata_valid = 1'b0;
      ctl_done        = 1'b1;
      tick();
      ctl_done = 1'b0;
   endtask

   // Port 2 write burst, one pop every other cycle, ctl_done after nbeats pops.
   task automatic write_burst(input int nbeats);
      do_reset();
      req_wdata[2*DATA_W +: DATA_W] = 16'hB000;
      req_valid     = 3'b100;
      ctl_cmd_ready = 1'b1;
      tick();
      check($sformatf("wr%0d_ack", nbeats), req_ack, 3'b100);
      check($sformatf("wr%0d_cmd_write", nbeats), ctl_cmd_write, 1);
      check($sformatf("wr%0d_cmd_addr", nbeats), ctl_cmd_addr, A2);
      tick();
      req_valid     = '0;
      ctl_cmd_ready = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         ctl_wdata_pop = 1'b1;
         #1;
         check($sformatf("wr%0d_pop%0d", nbeats, i), wdata_pop, 3'b100);
         check($sformatf("wr%0d_wdata%0d", nbeats, i), ctl_wdata, 16'hB000 + i);
         check($sformatf("wr%0d_last%0d", nbeats, i), rsp_last, i == BL - 1);
         tick();
         ctl_wdata_pop = 1'b0;
         req_wdata[2*DATA_W +: DATA_W] = 16'(16'hB000 + i + 1);
         #1;
         check($sformatf("wr%0d_nopop%0d", nbeats, i), wdata_pop, 3'b000);
         tick();
      end
      check($sformatf("wr%0d_err_before_done", nbeats), protocol_err, 0);
      ctl_done = 1'b1;
      tick();
      ctl_done = 1'b0;
      check($sformatf("wr%0d_protocol_err", nbeats), protocol_err, nbeats != BL);
   endtask

   initial begin
      int p;
      req_write       = 3'b100;
      req_addr        = {A2, A1, A0};
      req_wdata       = '0;
      req_valid       = '0;
      ctl_cmd_ready   = 1'b0;
      ctl_wdata_pop   = 1'b0;
      ctl_rdata_valid = 1'b0;
      ctl_rdata       = '0;
      ctl_done        = 1'b0;

      vecs[0] = '{3'b001, 1'b1, 0};
      vecs[1] = '{3'b010, 1'b1, 1};
      vecs[2] = '{3'b100, 1'b1, 2};
      vecs[3] = '{3'b110, 1'b1, 1};
      vecs[4] = '{3'b111, 1'b1, 0};
      vecs[5] = '{3'b101, 1'b1, 0};
      vecs[6] = '{3'b011, 1'b1, 0};
      vecs[7] = '{3'b000, 1'b0, 0};

      // Reset state
      repeat (2) @(posedge main_clk);
      #1;
      check("reset_ctl", {ctl_cmd_valid, ctl_cmd_refresh, ctl_cmd_write, refresh_overrun, protocol_err}, 0);
      check("reset_strobes", {req_ack, wdata_pop, rsp_valid, rsp_last}, 0);
      check("reset_addr", ctl_cmd_addr, 0);

      // Arbitration from reset, one edge of latency
      foreach (vecs[k]) begin
         do_reset();
         req_valid = vecs[k].valid;
         #1;
         check($sformatf("arb%0d_pre_edge", k), ctl_cmd_valid, 0);
         tick();
         check($sformatf("arb%0d_cmd_valid", k), ctl_cmd_valid, vecs[k].exp_cmd);
         check($sformatf("arb%0d_cmd_addr", k), ctl_cmd_addr,
               vecs[k].exp_cmd ? port_addr(vecs[k].exp_port) : '0);
         check($sformatf("arb%0d_cmd_write", k), ctl_cmd_write,
               vecs[k].exp_cmd && vecs[k].exp_port == 2);
         check($sformatf("arb%0d_cmd_refresh", k), ctl_cmd_refresh, 0);
      end

      // Single read burst on port 1
      do_reset();
      req_valid = 3'b010;
      ctl_cmd_ready = 1'b1;
      #1;
      check("rd_cmd_before_edge", ctl_cmd_valid, 0);
      tick();
      check("rd_cmd_valid", ctl_cmd_valid, 1);
      check("rd_cmd_addr", ctl_cmd_addr, A1);
      check("rd_cmd_write", ctl_cmd_write, 0);
      check("rd_ack", req_ack, 3'b010);
      tick();
      req_valid     = '0;
      ctl_cmd_ready = 1'b0;
      #1;
      check("rd_cmd_dropped", ctl_cmd_valid, 0);
      check("rd_ack_single", req_ack, 0);
      for (int i = 0; i < BL; i++) begin
         ctl_rdata_valid = 1'b1;
         ctl_rdata       = 16'(16'hA000 + i);
         #1;
         check($sformatf("rd_valid%0d", i), rsp_valid, 3'b010);
         check($sformatf("rd_data%0d", i), rsp_data, 16'hA000 + i);
         check($sformatf("rd_last%0d", i), rsp_last, i == BL - 1);
         tick();
      end
      ctl_rdata_valid = 1'b0;
      ctl_done        = 1'b1;
      #1;
      check("rd_no_valid_at_done", rsp_valid, 0);
      tick();
      ctl_done = 1'b0;
      check("rd_protocol_err", protocol_err, 0);
      check("rd_idle_after_done", ctl_cmd_valid, 0);

      // Grant order: port 0 priority, then round-robin 1/2
      do_reset();
      req_valid = 3'b111;
      for (int g = 0; g < 3; g++) begin
         serve(p);
         check($sformatf("order_p0_%0d", g), p, 0);
      end
      req_valid = 3'b110;
      for (int g = 0; g < 4; g++) begin
         serve(p);
         check($sformatf("order_rr_%0d", g), p, (g % 2 == 0) ? 1 : 2);
      end
      check("order_protocol_err", protocol_err, 0);

      // Write bursts on port 2: full length, then one beat short
      write_burst(BL);
      write_burst(BL - 1);

      // Data strobe outside a burst is ignored and flagged
      do_reset();
      ctl_rdata_valid = 1'b1;
      ctl_rdata       = 16'h1234;
      #1;
      check("stray_rsp_valid", rsp_valid, 0);
      check("stray_rsp_data", rsp_data, 0);
      tick();
      ctl_rdata_valid = 1'b0;
      check("stray_protocol_err", protocol_err, 1);

      // Refresh scheduling and overrun on the REFRESH_PERIOD=20 instance
      do_reset();
      for (int c = 1; c <= 21; c++) begin
         tick();
         if (c == 20) check("ref_not_before_21", r_cmd_valid, 0);
      end
      check("ref_cmd_valid_21", r_cmd_valid, 1);
      check("ref_cmd_refresh_21", r_cmd_refresh, 1);
      check("ref_no_overrun_yet", r_overrun, 0);
      check("ref_side_a", {r_req_ack, r_wdata_pop, r_rsp_valid, r_rsp_last, r_cmd_write, r_protocol_err}, 0);
      check("ref_side_b", {r_rsp_data, r_wdata, r_cmd_addr}, 0);
      repeat (24) tick();
      check("ref_cmd_held", {r_cmd_valid, r_cmd_refresh}, 2'b11);
      check("ref_overrun", r_overrun, 1);
      ctl_cmd_ready = 1'b1;
      tick();
      ctl_cmd_ready = 1'b0;
      check("ref_accepted", r_cmd_valid, 0);
      ctl_done = 1'b1;
      tick();
      ctl_done = 1'b0;
      check("ref_overrun_sticky", r_overrun, 1);

      // Asynchronous reset in the middle of a read burst
      do_reset();
      req_valid     = 3'b010;
      ctl_cmd_ready = 1'b1;
      tick();
      tick();
      req_valid     = '0;
      ctl_cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ctl_rdata_valid = 1'b1;
         ctl_rdata       = 16'(16'hC000 + i);
         tick();
      end
      ctl_rdata = 16'hC003;
      #1;
      check("mid_beat3_valid", rsp_valid, 3'b010);
      rst_n = 1'b0;
      #1;
      check("mid_reset_strobes", {req_ack, wdata_pop, rsp_valid, rsp_last, ctl_cmd_valid, ctl_cmd_refresh}, 0);
      check("mid_reset_data", {rsp_data, ctl_wdata, ctl_cmd_addr}, 0);
      check("mid_reset_flags", {ctl_cmd_write, refresh_overrun, protocol_err}, 0);
      ctl_rdata_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      req_valid     = 3'b010;
      ctl_cmd_ready = 1'b1;
      tick();
      check("post_reset_cmd_valid", ctl_cmd_valid, 1);
      check("post_reset_addr", ctl_cmd_addr, A1);
      check("post_reset_ack", req_ack, 3'b010);
      tick();
      req_valid     = '0;
      ctl_cmd_ready = 1'b0;
      check("post_reset_protocol_err", protocol_err, 0);

`ifdef DRAM_ARB_STARVATION_GUARD_EN
      // Port 0 always valid: port 2 still gets through once its wait counter saturates
      begin : starve
         int   start;
         logic got2;
         do_reset();
         req_valid = 3'b101;
         start     = cyc;
         got2      = 1'b0;
         for (int b = 0; b < 12 && !got2; b++) begin
            serve(p);
            if (p == 2) got2 = 1'b1;
         end
         check("starve_port2_granted", got2, 1);
         check("starve_latency", (ack_cyc - start) <= 64 + 12, 1);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
